uart_frame_decoder: RTL
=======================

// Module: uart_frame_decoder
// PURPOSE
//  Framed-packet reader on the receive side of the UART link. Sits directly behind
//  uart_rx, consuming its byte stream over valid/ready, and recovers frames of the form
//  SOF, LEN, PAYLOAD[LEN], CSUM. Payload is buffered internally and released downstream
//  only after the checksum verifies. Bad frames are dropped and flagged.
// PARAMETERS
//  SOF_BYTE        8'hA5    start-of-frame marker
//  MAX_LEN         16       max payload bytes (1..255); buffer depth
//  TIMEOUT_CYCLES  100000   inter-byte gap limit in clk cycles (used only with macro)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  in_data    in   8  byte from uart_rx (rx_data)
//  in_valid   in   1  byte valid (rx_data_valid)
//  in_ready   out  1  decoder accepts byte (drives rx_data_ready)
//  out_data   out  8  verified payload byte
//  out_valid  out  1  out_data valid
//  out_ready  in   1  downstream accepts out_data
//  out_last   out  1  marks final payload byte of frame
//  frame_done out  1  1-cycle pulse: frame fully delivered
//  frame_err  out  1  1-cycle pulse: frame rejected
//  err_code   out  2  cause of last rejection, held: 1=LEN, 2=CSUM, 3=TIMEOUT
// BEHAVIOUR
//  - One clock; reset asynchronous active-low. Reset values: state=IDLE, out_valid=0,
//    out_last=0, out_data=0, frame_done=0, frame_err=0, err_code=0, sum=0, counters=0.
//  - Byte accepted when in_valid & in_ready. in_ready = (state != DRAIN), combinational
//    from state; 1 in reset and IDLE.
//  - FSM: IDLE -> LEN -> PAYLOAD -> CSUM -> DRAIN -> IDLE.
//    IDLE: accepted byte == SOF_BYTE -> LEN; any other byte discarded silently.
//    LEN: 1..MAX_LEN -> store len, sum=len, wr_ptr=0 -> PAYLOAD; 0 or >MAX_LEN ->
//      frame_err, err_code=1 -> IDLE.
//    PAYLOAD: write byte to buf[wr_ptr], sum+=byte (mod 256); after len-th byte -> CSUM.
//      SOF_BYTE inside payload is ordinary data.
//    CSUM: byte == sum -> DRAIN, rd_ptr=0; else frame_err, err_code=2 -> IDLE.
//    DRAIN: present buf[rd_ptr]; advance on out_valid & out_ready; out_last high with
//      rd_ptr==len-1; after last handshake -> frame_done pulse next cycle, IDLE.
//  - Checksum: 8-bit modulo-256 sum of LEN and all payload bytes.
//  - Latency: out_valid rises the cycle after the accepted matching CSUM byte.
//  - out_data/out_valid/out_last stable while out_valid & !out_ready.
//  - frame_err asserted the cycle after the offending byte/event; err_code updated same
//    cycle, held until next error or reset. frame_done and frame_err never coincide.
//  - Rejected frame: buffer contents discarded, no out_valid.
//  - Reset mid-frame or mid-drain: partial frame discarded, outputs to reset values.
// CONFIGURATION
//  UART_FRAME_TIMEOUT_EN defined: gap counter clears on each accepted byte, counts while
//    state in {LEN,PAYLOAD,CSUM}; reaching TIMEOUT_CYCLES -> frame_err, err_code=3 -> IDLE.
//    Counter idle in IDLE and DRAIN.
//  Not defined: no counter; partial frames wait indefinitely; err_code 3 never produced.
// TESTING
//  1 A5 03 11 22 33 69, out_ready=1 -> out 11,22,33, out_last on 33, one frame_done, no err;
//    repeat end-to-end through uart_tx->uart_rx at CLK_FRE=100, BAUD_RATE=115200.
//  2 A5 02 10 20 00 -> no out_valid, frame_err, err_code=2; next A5 01 7E 7F -> out 7E.
//  3 A5 00 and A5 11 (MAX_LEN=16) -> frame_err, err_code=1 each; junk 00 FF 5A before a
//    SOF ignored; A5 02 A5 01 A8 -> out A5,01.
//  4 Frame of 16 bytes with out_ready toggling 1/0 and in_valid held high -> in_ready=0
//    throughout DRAIN, all 16 bytes in order, nothing lost or duplicated.
//  5 Macro on, TIMEOUT_CYCLES=50: A5 03 11 22 then 51-cycle gap -> err_code=3, back to IDLE;
//    macro off, same stimulus then 33 44 -> frame delivered.
//  6 rst_n low for 3 cycles mid-PAYLOAD and mid-DRAIN -> outputs at reset values, next
//    clean frame decodes correctly.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - SOF/LEN/PAYLOAD/CSUM frame decoder; payload released only after checksum match
// Optional inter-byte gap timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         sum_q, sum_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         pl_mem [MAX_LEN];
  logic               accept;
  logic               wr_en;
  logic               timeout_hit;

  assign in_ready   = (state_q != S_DRAIN);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state_q == S_DRAIN);
  assign out_data   = out_valid ? pl_mem[rd_ptr_q] : 8'h00;
  assign out_last   = out_valid && (8'(rd_ptr_q) == len_q - 8'd1);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Gap counter only runs while a frame is partially received.
  always_comb begin
    gap_d       = '0;
    timeout_hit = 1'b0;
    if ((state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM)) begin
      if (!accept) begin
        gap_d       = gap_q + GAP_W'(1);
        timeout_hit = (gap_d == GAP_W'(TIMEOUT_CYCLES));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    wr_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SOF_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = S_IDLE;
          end else begin
            len_d    = in_data;
            sum_d    = in_data;
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          sum_d    = sum_q + in_data;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (8'(wr_ptr_q) == len_q - 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == sum_q) begin
            rd_ptr_d = '0;
            state_d  = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout can only fire on a cycle with no accepted byte, so it never races the cases above.
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pl_mem[wr_ptr_q] <= in_data;
  end

endmodule
